mux8_rr_arbiter: RTL and testbench
==================================

Name: mux8_rr_arbiter

Overview:
- Shares one 8:1 N-bit data mux (mux_8NtoN) between eight requesters using round-robin arbitration with a bounded burst hold.
- Drives the mux select and enable, and registers the selected word into a single valid/ready output stage.
- Sits between eight producer blocks and a single consumer, e.g. a shared write-back or bus port in the processor.

Parameters:
- N, 32, data width of each requester input and of the output.
- MAX_BURST, 4, maximum consecutive grants to one requester while it keeps requesting (range 1..16; 1 = pure round-robin).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- req  input  8  request bits; req[i] means data on Ii is offered.
- I0..I7  input  N each  requester data words.
- ack  output  8  one-hot combinational accept; ack[i]=1 in the cycle Ii is captured; requester i may change Ii/drop req[i] after that edge.
- O  output  N  registered output data.
- out_valid  output  1  O holds a valid word.
- out_ready  input  1  consumer accepts O this cycle.
- sel  output  3  index of the requester whose word is currently in O (drives mux S).
- enable  output  1  mux enable; equals out_valid.

Behaviour:
- Reset (async, rst=1): O=0, out_valid=0, sel=0, enable=0, last=7, burst_cnt=MAX_BURST-1. No hold is active after reset, so the first priority start is requester 0. ack=0 while rst=1.
- States: EMPTY (out_valid=0) and FULL (out_valid=1).
- load = |req && (!out_valid || out_ready). load is evaluated combinationally each cycle.
- Priority start:
  - hold = req[last] && burst_cnt < MAX_BURST-1.
  - start = hold ? last : (last+1) mod 8.
  - winner w = first i with req[i]=1, scanning start, start+1, ... modulo 8.
- On load:
  - ack[w]=1 during the cycle.
  - At the edge: O<=Iw, out_valid<=1, sel<=w.
  - If w==last, burst_cnt<=burst_cnt+1, saturating at MAX_BURST-1; otherwise burst_cnt<=0.
  - last<=w.
- Pop without reload (out_valid && out_ready && !load): at the edge out_valid<=0 and O<=0, so O reads 0 whenever enable=0.
- Hold (out_valid && !out_ready): O, sel, out_valid, last and burst_cnt are unchanged, and ack=0.
- Simultaneous pop and load: back-to-back transfer, one word per cycle; load latency from req to O is 1 cycle.
- No requests and no pop: state unchanged.
- Dropping req[last] ends the burst immediately; the next grant starts at last+1.
- Wrap-around: index arithmetic is modulo 8 (7+1 -> 0).
- Reset mid-operation: any held word is discarded with no ack and no output, and state returns to the reset values.
- ack is never asserted for an index whose req=0. At most one ack bit is set per cycle.

Decomposition:
- Package mux_arb_pkg:
  - NUM_REQ=8, SEL_W=3.
  - state enum {EMPTY, FULL}.
  - helper function next_idx(idx) returning (idx+1) mod 8.
- Sub-module rr_pick8 (combinational): inputs req[7:0] and start[2:0]; outputs any, winner[2:0] and onehot[7:0].
- Data selection reuses the existing mux_8NtoN, with S=winner and enable=load; its output feeds the O register.

Test Plan:
- Reset/idle:
  - Assert rst for 3 cycles with req=8'hFF → O=0, out_valid=0, sel=0, ack=0.
  - Release rst with req=0 for 5 cycles → no change.
- Single requester:
  - req=8'b0000_0100, I2=32'hA5A5_0002, out_ready=1.
  - → ack=8'b0000_0100 in that cycle; next cycle O=32'hA5A5_0002, sel=2, out_valid=1, enable=1.
- Round-robin fairness, MAX_BURST=1:
  - req=8'hFF held, out_ready=1, Ii=i.
  - → sel sequence 0,1,2,...,7,0 over 9 consecutive cycles, one ack per cycle.
- Burst hold, MAX_BURST=4:
  - req=8'b0000_1001 held, out_ready=1.
  - → grants 0,0,0,0,3,3,3,3,0.
  - Dropping req[0] after its second grant → next grant is 3.
- Backpressure:
  - FULL with O=I5=32'h1234_5678, out_ready=0 for 4 cycles, req=8'hFF.
  - → O and sel=5 stable, ack=0.
  - Then out_ready=1 → the next word is captured in the same cycle (ack=8'b0100_0000).
  - Then req=0, out_ready=1 → out_valid=0, O=0.
- Async reset mid-stream:
  - Assert rst between clock edges while FULL with out_ready=0.
  - → O=0 and out_valid=0 immediately, without waiting for a clock edge.
  - After release with req=8'hFF → the first grant is requester 0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared constants, state type and index helper for the 8-way round-robin arbiter
package mux_arb_pkg;

    localparam int NUM_REQ     = 8;
    localparam int SEL_W       = 3;
    localparam int BURST_CNT_W = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
        return idx + SEL_W'(1);
    endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// rtl/mux8_rr_arbiter_if.sv - requester/consumer bundle seen by the shared 8:1 mux arbiter
interface mux8_rr_arbiter_if #(
    parameter int N = 32
);
    import mux_arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [N-1:0]       I0, I1, I2, I3, I4, I5, I6, I7;
    logic [NUM_REQ-1:0] ack;
    logic [N-1:0]       O;
    logic               out_valid;
    logic               out_ready;
    logic [SEL_W-1:0]   sel;
    logic               enable;

    modport master (
        output req, I0, I1, I2, I3, I4, I5, I6, I7, out_ready,
        input  ack, O, out_valid, sel, enable
    );

    modport slave (
        input  req, I0, I1, I2, I3, I4, I5, I6, I7, out_ready,
        output ack, O, out_valid, sel, enable
    );

endinterface

// File: rtl/mux_8NtoN.sv
// rtl/mux_8NtoN.sv - 8:1 N-bit data mux with enable; output is zero when disabled
module mux_8NtoN #(
    parameter int N = 32
) (
    input  logic [N-1:0] I0,
    input  logic [N-1:0] I1,
    input  logic [N-1:0] I2,
    input  logic [N-1:0] I3,
    input  logic [N-1:0] I4,
    input  logic [N-1:0] I5,
    input  logic [N-1:0] I6,
    input  logic [N-1:0] I7,
    input  logic [2:0]   S,
    input  logic         enable,
    output logic [N-1:0] O
);

    always_comb begin
        O = '0;
        if (enable) begin
            case (S)
                3'd0:    O = I0;
                3'd1:    O = I1;
                3'd2:    O = I2;
                3'd3:    O = I3;
                3'd4:    O = I4;
                3'd5:    O = I5;
                3'd6:    O = I6;
                default: O = I7;
            endcase
        end
    end

endmodule

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - first active request found scanning upward from start, modulo 8
module rr_pick8
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   start,
    output logic               any,
    output logic [SEL_W-1:0]   winner,
    output logic [NUM_REQ-1:0] onehot
);

    always_comb begin
        logic [SEL_W-1:0] idx;
        idx    = '0;
        winner = '0;
        any    = |req;
        // Scan from the far end back toward start so the nearest hit is written last.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = start + SEL_W'(k);
            if (req[idx]) begin
                winner = idx;
            end
        end
        onehot = any ? (NUM_REQ'(1) << winner) : '0;
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// rtl/mux8_rr_arbiter.sv - round-robin arbiter with bounded burst hold feeding one registered valid/ready stage
module mux8_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N         = 32,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    mux8_rr_arbiter_if.slave bus
);

    localparam logic [BURST_CNT_W-1:0] CNT_MAX = BURST_CNT_W'(MAX_BURST - 1);

    state_t                   state;
    state_t                   state_nx;
    logic [SEL_W-1:0]         last;
    logic [SEL_W-1:0]         start;
    logic [SEL_W-1:0]         winner;
    logic [SEL_W-1:0]         sel_q;
    logic [BURST_CNT_W-1:0]   burst_cnt;
    logic [NUM_REQ-1:0]       onehot;
    logic [N-1:0]             mux_o;
    logic [N-1:0]             o_q;
    logic                     any;
    logic                     hold;
    logic                     load;
    logic                     pop;
    logic                     out_valid_c;
    logic [NUM_REQ-1:0]       ack_c;

    // The previous winner keeps priority only while it still requests and has burst budget left.
    assign hold  = bus.req[last] && (burst_cnt < CNT_MAX);
    assign start = hold ? last : next_idx(last);

    rr_pick8 u_pick (
        .req    (bus.req),
        .start  (start),
        .any    (any),
        .winner (winner),
        .onehot (onehot)
    );

    assign pop  = (state == FULL) && bus.out_ready;
    assign load = any && ((state == EMPTY) || bus.out_ready);

    mux_8NtoN #(.N(N)) u_mux (
        .I0     (bus.I0),
        .I1     (bus.I1),
        .I2     (bus.I2),
        .I3     (bus.I3),
        .I4     (bus.I4),
        .I5     (bus.I5),
        .I6     (bus.I6),
        .I7     (bus.I7),
        .S      (winner),
        .enable (load),
        .O      (mux_o)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (load) begin
            state_nx = FULL;
        end else if (pop) begin
            state_nx = EMPTY;
        end
    end

    always_comb begin
        out_valid_c = (state == FULL);
        ack_c       = '0;
        if (load && !rst) begin
            ack_c = onehot;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_q       <= '0;
            sel_q     <= '0;
            last      <= SEL_W'(NUM_REQ - 1);
            burst_cnt <= CNT_MAX;
        end else if (load) begin
            o_q   <= mux_o;
            sel_q <= winner;
            last  <= winner;
            if (winner == last) begin
                burst_cnt <= (burst_cnt == CNT_MAX) ? CNT_MAX : burst_cnt + 1'b1;
            end else begin
                burst_cnt <= '0;
            end
        end else if (pop) begin
            // O is kept at zero whenever no word is presented.
            o_q <= '0;
        end
    end

    assign bus.O         = o_q;
    assign bus.sel       = sel_q;
    assign bus.out_valid = out_valid_c;
    assign bus.enable    = out_valid_c;
    assign bus.ack       = ack_c;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb/tb_mux8_rr_arbiter.sv - randomized and directed bench for two arbiter instances (MAX_BURST 1 and 4)
module tb_mux8_rr_arbiter;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   req;
    logic         out_ready;
    logic [N-1:0] din [8];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux8_rr_arbiter_if #(.N(N)) bus1 ();
    mux8_rr_arbiter_if #(.N(N)) bus4 ();

    assign bus1.req = req;  assign bus4.req = req;
    assign bus1.out_ready = out_ready;  assign bus4.out_ready = out_ready;
    assign bus1.I0 = din[0];  assign bus4.I0 = din[0];
    assign bus1.I1 = din[1];  assign bus4.I1 = din[1];
    assign bus1.I2 = din[2];  assign bus4.I2 = din[2];
    assign bus1.I3 = din[3];  assign bus4.I3 = din[3];
    assign bus1.I4 = din[4];  assign bus4.I4 = din[4];
    assign bus1.I5 = din[5];  assign bus4.I5 = din[5];
    assign bus1.I6 = din[6];  assign bus4.I6 = din[6];
    assign bus1.I7 = din[7];  assign bus4.I7 = din[7];

    mux8_rr_arbiter #(.N(N), .MAX_BURST(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    mux8_rr_arbiter #(.N(N), .MAX_BURST(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    // Reference: run length of consecutive grants to the last winner, per instance.
    int           mb [2] = '{1, 4};
    int           m_last [2];
    int           m_run [2];
    int           m_sel [2];
    logic [N-1:0] m_o [2];
    bit           m_valid [2];

    task automatic chk(input string tag, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_last[k] = 7; m_run[k] = mb[k]; m_sel[k] = 0; m_o[k] = '0; m_valid[k] = 1'b0;
        end
    endtask

    function automatic int model_pick(input int k);
        int first;
        first = (req[m_last[k]] && m_run[k] < mb[k]) ? m_last[k] : (m_last[k] + 1) % 8;
        for (int j = 0; j < 8; j++) begin
            if (req[(first + j) % 8]) return (first + j) % 8;
        end
        return -1;
    endfunction

    function automatic bit model_load(input int k);
        return (req != 8'h00) && (!m_valid[k] || out_ready);
    endfunction

    function automatic logic [7:0] model_ack(input int k);
        if (rst || !model_load(k)) return 8'h00;
        return 8'h01 << model_pick(k);
    endfunction

    task automatic model_clock(input int k);
        int w;
        w = model_pick(k);
        if (model_load(k)) begin
            m_o[k] = din[w]; m_valid[k] = 1'b1; m_sel[k] = w;
            m_run[k] = (w == m_last[k]) ? ((m_run[k] < mb[k]) ? m_run[k] + 1 : mb[k]) : 1;
            m_last[k] = w;
        end else if (m_valid[k] && out_ready) begin
            m_valid[k] = 1'b0; m_o[k] = '0;
        end
    endtask

    task automatic check_outputs();
        chk("o_mb1",     bus1.O, m_o[0]);
        chk("valid_mb1", 32'(bus1.out_valid), 32'(m_valid[0]));
        chk("en_mb1",    32'(bus1.enable), 32'(m_valid[0]));
        chk("sel_mb1",   32'(bus1.sel), 32'(m_sel[0]));
        chk("o_mb4",     bus4.O, m_o[1]);
        chk("valid_mb4", 32'(bus4.out_valid), 32'(m_valid[1]));
        chk("en_mb4",    32'(bus4.enable), 32'(m_valid[1]));
        chk("sel_mb4",   32'(bus4.sel), 32'(m_sel[1]));
    endtask

    task automatic step();
        logic [7:0] ea0, ea4;
        #1;
        ea0 = model_ack(0);
        ea4 = model_ack(1);
        chk("ack_mb1", 32'(bus1.ack), 32'(ea0));
        chk("ack_mb4", 32'(bus4.ack), 32'(ea4));
        @(posedge clk);
        model_clock(0);
        model_clock(1);
        #1;
        check_outputs();
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        model_reset();
        repeat (cycles) begin
            #1;
            chk("rst_ack_mb1", 32'(bus1.ack), 32'h0);
            chk("rst_ack_mb4", 32'(bus4.ack), 32'h0);
            @(posedge clk);
            #1;
            check_outputs();
        end
        rst = 1'b0;
    endtask

    // Reset raised between edges must clear the output stage without a clock.
    task automatic async_reset_pulse();
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_o_mb1",     bus1.O, 32'h0);
        chk("arst_valid_mb1", 32'(bus1.out_valid), 32'h0);
        chk("arst_o_mb4",     bus4.O, 32'h0);
        chk("arst_valid_mb4", 32'(bus4.out_valid), 32'h0);
        chk("arst_ack_mb1",   32'(bus1.ack), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int burst_seq [9] = '{0, 0, 0, 0, 3, 3, 3, 3, 0};

        rst = 1'b1;
        req = 8'hFF;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) din[i] = '0;
        do_reset(3);

        req = 8'h00;
        repeat (5) step();

        req = 8'b0000_0100; din[2] = 32'hA5A5_0002; out_ready = 1'b1;
        #1;
        chk("single_ack", 32'(bus1.ack), 32'h04);
        step();
        chk("single_o",   bus4.O, 32'hA5A5_0002);
        chk("single_sel", 32'(bus4.sel), 32'd2);

        do_reset(1);
        req = 8'hFF;
        for (int i = 0; i < 8; i++) din[i] = N'(i);
        for (int i = 0; i < 9; i++) begin
            step();
            chk("rr_sel", 32'(bus1.sel), 32'(i % 8));
        end

        do_reset(1);
        req = 8'b0000_1001;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("burst_sel", 32'(bus4.sel), 32'(burst_seq[i]));
        end

        do_reset(1);
        req = 8'b0000_1001;
        repeat (2) step();
        req = 8'b0000_1000;
        step();
        chk("drop_sel", 32'(bus4.sel), 32'd3);

        do_reset(1);
        req = 8'b0010_0000; din[5] = 32'h1234_5678; out_ready = 1'b1;
        step();
        out_ready = 1'b0; req = 8'hFF;
        repeat (4) begin
            step();
            chk("bp_o",   bus1.O, 32'h1234_5678);
            chk("bp_sel", 32'(bus1.sel), 32'd5);
            chk("bp_ack", 32'(bus1.ack), 32'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ack", 32'(bus1.ack), 32'h40);
        step();
        req = 8'h00;
        step();
        chk("drain_valid", 32'(bus1.out_valid), 32'h0);
        chk("drain_o",     bus1.O, 32'h0);

        req = 8'hFF; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        async_reset_pulse();
        req = 8'hFF; out_ready = 1'b1;
        #1;
        chk("arst_first_ack", 32'(bus1.ack), 32'h01);
        step();
        chk("arst_first_sel", 32'(bus4.sel), 32'd0);

        for (int c = 0; c < 600; c++) begin
            case ($urandom_range(0, 3))
                0:       req = 8'($urandom);
                1:       req = 8'($urandom) & 8'($urandom);
                2:       req = 8'h01 << $urandom_range(0, 7);
                default: req = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'hFF;
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 8; i++) din[i] = $urandom;
            if ($urandom_range(0, 99) == 0) begin
                async_reset_pulse();
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
